// File: rtl/jtopl_mixacc_if.sv
// rtl/jtopl_mixacc_if.sv - slot input / stereo sample output bundle for jtopl_mixacc
interface jtopl_mixacc_if #(
  parameter int OPW  = 13,
  parameter int OUTW = 16
);
  logic                   cenop;
  logic signed [OPW-1:0]  op_result;
  logic                   zero;
  logic                   op;
  logic                   con;
  logic                   ch_l;
  logic                   ch_r;
  logic [1:0]             gain;
  logic signed [OUTW-1:0] snd_l;
  logic signed [OUTW-1:0] snd_r;
  logic                   sample;
  logic                   clip;
  logic                   frame_err;

  modport master (
    output cenop, op_result, zero, op, con, ch_l, ch_r, gain,
    input  snd_l, snd_r, sample, clip, frame_err
  );

  modport slave (
    input  cenop, op_result, zero, op, con, ch_l, ch_r, gain,
    output snd_l, snd_r, sample, clip, frame_err
  );
endinterface

// File: rtl/jtopl_mixacc.sv
// rtl/jtopl_mixacc.sv - per-frame stereo operator accumulator with gain, saturation and frame check
// JTOPL_MIXACC_CLIP_EN selects saturation + clip flag; otherwise the output wraps and clip is 0.
module jtopl_mixacc #(
  parameter int OPW   = 13,
  parameter int OUTW  = 16,
  parameter int SLOTS = 18,
  parameter int ACCW  = OPW + $clog2(SLOTS)
) (
  input  logic           clk,
  input  logic           rst,
  jtopl_mixacc_if.slave  bus
);

  localparam int SW = ACCW + 3;
  localparam int CW = $clog2(SLOTS + 1);

  logic signed [ACCW-1:0] acc_l_q, acc_l_d;
  logic signed [ACCW-1:0] acc_r_q, acc_r_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   armed_q, armed_d;
  logic signed [OUTW-1:0] snd_l_q, snd_l_d;
  logic signed [OUTW-1:0] snd_r_q, snd_r_d;
  logic                   sample_q, sample_d;
  logic                   clip_q, clip_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sum_en;
  logic signed [ACCW-1:0] op_ext;
  logic signed [ACCW-1:0] add_l, add_r;
  logic signed [SW-1:0]   shl_l, shl_r;
  logic signed [OUTW-1:0] out_l, out_r;
  logic                   clip_now;

  assign sum_en = bus.op | bus.con;
  assign op_ext = {{(ACCW-OPW){bus.op_result[OPW-1]}}, bus.op_result};
  assign add_l  = (sum_en & bus.ch_l) ? op_ext : '0;
  assign add_r  = (sum_en & bus.ch_r) ? op_ext : '0;

  // Three guard bits keep acc << 3 exact before any narrowing.
  assign shl_l = {{3{acc_l_q[ACCW-1]}}, acc_l_q} <<< bus.gain;
  assign shl_r = {{3{acc_r_q[ACCW-1]}}, acc_r_q} <<< bus.gain;

`ifdef JTOPL_MIXACC_CLIP_EN
  localparam logic signed [OUTW-1:0] MAXV = {1'b0, {(OUTW-1){1'b1}}};
  localparam logic signed [OUTW-1:0] MINV = {1'b1, {(OUTW-1){1'b0}}};

  // Value fits when every bit above the output sign bit matches the sign.
  function automatic logic fits(input logic signed [SW-1:0] v);
    return v[SW-1:OUTW-1] == {(SW-OUTW+1){v[SW-1]}};
  endfunction

  logic fit_l, fit_r;
  assign fit_l    = fits(shl_l);
  assign fit_r    = fits(shl_r);
  assign out_l    = fit_l ? shl_l[OUTW-1:0] : (shl_l[SW-1] ? MINV : MAXV);
  assign out_r    = fit_r ? shl_r[OUTW-1:0] : (shl_r[SW-1] ? MINV : MAXV);
  assign clip_now = ~fit_l | ~fit_r;
`else
  assign out_l    = OUTW'(shl_l);
  assign out_r    = OUTW'(shl_r);
  assign clip_now = 1'b0;
`endif

  always_comb begin
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    snd_l_d     = snd_l_q;
    snd_r_d     = snd_r_q;
    sample_d    = 1'b0;
    clip_d      = clip_q;
    frame_err_d = frame_err_q;
    if (bus.cenop) begin
      if (bus.zero) begin
        // The zero slot opens the new frame, so it seeds the accumulators.
        acc_l_d     = add_l;
        acc_r_d     = add_r;
        cnt_d       = '0;
        armed_d     = 1'b1;
        snd_l_d     = out_l;
        snd_r_d     = out_r;
        sample_d    = 1'b1;
        clip_d      = clip_now;
        frame_err_d = armed_q && (cnt_q != CW'(SLOTS - 1));
      end else begin
        acc_l_d = acc_l_q + add_l;
        acc_r_d = acc_r_q + add_r;
        if (cnt_q != CW'(SLOTS))
          cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      snd_l_q     <= '0;
      snd_r_q     <= '0;
      sample_q    <= 1'b0;
      clip_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      snd_l_q     <= snd_l_d;
      snd_r_q     <= snd_r_d;
      sample_q    <= sample_d;
      clip_q      <= clip_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.snd_l     = snd_l_q;
  assign bus.snd_r     = snd_r_q;
  assign bus.sample    = sample_q;
  assign bus.clip      = clip_q;
  assign bus.frame_err = frame_err_q;

endmodule
